// File: rtl/cam_frame_capture.sv
// Camera byte bus to 16-bit pixel stream bridge.
// Pairs hi/lo camera bytes into RGB565 pixels for one frame per shutter request,
// and queues them in a show-ahead FIFO for a ready/valid sink. Overflow and
// truncated frames are flagged sticky until the next shutter request.
module cam_frame_capture #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cam_data,
    input  logic        cam_href,
    input  logic        cam_vsync,
    input  logic        cam_shutter,
    input  logic        continuous,
    output logic [15:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_sop,
    output logic        src_eop,
    output logic        busy,
    output logic        overflow,
    output logic        frame_err,
    output logic [15:0] frame_count
);

    localparam int unsigned XW = $clog2(H_PIXELS + 1);
    localparam int unsigned YW = $clog2(V_LINES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [XW-1:0] XEnd  = XW'(H_PIXELS);
    localparam logic [XW-1:0] XLast = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] YEnd  = YW'(V_LINES);
    localparam logic [YW-1:0] YLast = YW'(V_LINES - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrop} state_e;

    // Input stage R and its delayed copy used for edge detection
    logic [7:0] data_r_q;
    logic       href_r_q, href_d_q;
    logic       vsync_r_q, vsync_d_q;
    logic       shutter_r_q, shutter_d_q;

    logic       shutter_rise, vsync_rise, vsync_fall, href_fall;

    // Capture state
    state_e          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic            phase_q;
    logic [7:0]      hi_q;
    logic            overflow_q;
    logic            frame_err_q;
    logic [15:0]     frame_count_q;

    // Registered FIFO write request {sop, eop, data}
    logic            wr_pend_q;
    logic [17:0]     wr_entry_q;

    // FIFO storage
    logic [17:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [17:0]     head;
    logic            push, pop;
    logic [AW+1:0]   occ;
    logic            fifo_full;

    logic            pix_write, pix_sop, pix_last;
    state_e          rearm_state;

    // Register camera inputs once and keep a delayed copy for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r_q    <= 8'h00;
            href_r_q    <= 1'b0;
            href_d_q    <= 1'b0;
            vsync_r_q   <= 1'b0;
            vsync_d_q   <= 1'b0;
            shutter_r_q <= 1'b0;
            shutter_d_q <= 1'b0;
        end else begin
            data_r_q    <= cam_data;
            href_r_q    <= cam_href;
            href_d_q    <= href_r_q;
            vsync_r_q   <= cam_vsync;
            vsync_d_q   <= vsync_r_q;
            shutter_r_q <= cam_shutter;
            shutter_d_q <= shutter_r_q;
        end
    end

    // Edge detection, pixel write qualification and FIFO occupancy check
    always_comb begin
        shutter_rise = shutter_r_q & ~shutter_d_q;
        vsync_rise   = vsync_r_q & ~vsync_d_q;
        vsync_fall   = ~vsync_r_q & vsync_d_q;
        href_fall    = ~href_r_q & href_d_q;

        pix_write = (state_q == StCapture) && href_r_q && phase_q &&
                    (x_q < XEnd) && (y_q < YEnd);
        pix_sop   = (x_q == '0) && (y_q == '0);
        pix_last  = (x_q == XLast) && (y_q == YLast);

        rearm_state = continuous ? StArmed : StIdle;

        // Count the pending write and the pop happening this cycle so a
        // pixel is only accepted when its slot is guaranteed on landing.
        occ = {1'b0, count_q} + (AW+2)'(wr_pend_q) - (AW+2)'(pop);
        fifo_full = (occ >= (AW+2)'(FIFO_DEPTH));
    end

    // Frame capture FSM with its sticky flags, counters and write request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            x_q           <= '0;
            y_q           <= '0;
            phase_q       <= 1'b0;
            hi_q          <= 8'h00;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'h0000;
            wr_pend_q     <= 1'b0;
            wr_entry_q    <= '0;
        end else begin
            wr_pend_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (shutter_rise) begin
                        state_q     <= StArmed;
                        overflow_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                StArmed: begin
                    if (vsync_fall) begin
                        state_q <= StCapture;
                        x_q     <= '0;
                        y_q     <= '0;
                        phase_q <= 1'b0;
                    end
                end
                StCapture: begin
                    if (href_r_q) begin
                        phase_q <= ~phase_q;
                        if (!phase_q) begin
                            hi_q <= data_r_q;
                        end
                    end else if (href_fall) begin
                        // Any odd trailing byte is dropped by resetting phase
                        x_q     <= '0;
                        phase_q <= 1'b0;
                        if (y_q != YEnd) begin
                            y_q <= y_q + YW'(1);
                        end
                    end

                    if (pix_write && fifo_full) begin
                        overflow_q <= 1'b1;
                        state_q    <= StDrop;
                    end else begin
                        if (pix_write) begin
                            wr_pend_q  <= 1'b1;
                            wr_entry_q <= {pix_sop, pix_last, hi_q, data_r_q};
                            x_q        <= x_q + XW'(1);
                        end
                        // Last-pixel write wins over a coincident vsync rise
                        if (pix_write && pix_last) begin
                            frame_count_q <= frame_count_q + 16'd1;
                            state_q       <= rearm_state;
                        end else if (vsync_rise) begin
                            frame_err_q <= 1'b1;
                            state_q     <= rearm_state;
                        end
                    end
                end
                StDrop: begin
                    if (vsync_rise) begin
                        state_q <= rearm_state;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign push = wr_pend_q;
    assign pop  = src_valid & src_ready;

    // FIFO storage needs no reset; outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Show-ahead head entry drives the stream outputs
    always_comb begin
        head      = mem[rd_ptr_q];
        src_valid = (count_q != '0);
        src_data  = src_valid ? head[15:0] : 16'h0000;
        src_eop   = src_valid & head[16];
        src_sop   = src_valid & head[17];
    end

    assign busy        = (state_q != StIdle);
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture with a 4x2 frame and a 4-entry FIFO.
module tb_cam_frame_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cam_data;
    logic        cam_href;
    logic        cam_vsync;
    logic        cam_shutter;
    logic        continuous;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        src_sop;
    logic        src_eop;
    logic        busy;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_bad = 0;
    int bk    = 0;

    logic [17:0] beats [$];

    cam_frame_capture #(
        .H_PIXELS   (4),
        .V_LINES    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cam_data    (cam_data),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .cam_shutter (cam_shutter),
        .continuous  (continuous),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .busy        (busy),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Record every accepted beat as {sop, eop, data}
    always @(negedge clk) begin
        if (!reset && src_valid && src_ready) begin
            beats.push_back({src_sop, src_eop, src_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic sop,
                              input logic eop, input logic [15:0] data);
        logic [17:0] obs;
        obs = (idx < beats.size()) ? beats[idx] : 18'h3ffff;
        check($sformatf("%s[%0d]", tag, idx), 32'(obs), 32'({sop, eop, data}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte();
        cam_href = 1'b1;
        cam_data = 8'h12 + 8'(bk * 34);
        bk++;
        tick();
    endtask

    task automatic send_pixels(input int n);
        repeat (2 * n) send_byte();
    endtask

    task automatic end_line();
        cam_href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        bk = 0;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic shutter();
        cam_shutter = 1'b1;
        repeat (2) tick();
        cam_shutter = 1'b0;
        repeat (2) tick();
    endtask

    task automatic full_frame(input int ppl, input bit odd);
        frame_start();
        for (int l = 0; l < 2; l++) begin
            send_pixels(ppl);
            if (odd) send_byte();
            end_line();
        end
        frame_end();
    endtask

    initial begin
        int base;
        int nsop;
        int neop;

        reset       = 1'b1;
        cam_data    = 8'h00;
        cam_href    = 1'b0;
        cam_vsync   = 1'b1;
        cam_shutter = 1'b0;
        continuous  = 1'b0;
        src_ready   = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_valid", 32'(src_valid), 0);
        check("rst_data", 32'(src_data), 0);
        check("rst_sop_eop", 32'({src_sop, src_eop}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", 32'({overflow, frame_err}), 0);
        check("rst_count", 32'(frame_count), 0);
        reset = 1'b0;
        repeat (2) tick();

        // T1: nominal frame, latency of the first pixel
        base = beats.size();
        shutter();
        check("t1_busy_armed", 32'(busy), 1);
        frame_start();
        send_byte();
        send_byte();
        check("t1_lat_n", 32'(src_valid), 0);
        send_byte();
        check("t1_lat_n1", 32'(src_valid), 0);
        send_byte();
        check("t1_lat_n2", 32'(src_valid), 1);
        check("t1_head", 32'({src_sop, src_eop, src_data}), 32'({2'b10, 16'h1234}));
        send_pixels(2);
        end_line();
        send_pixels(4);
        end_line();
        check("t1_busy_done", 32'(busy), 0);
        check("t1_count", 32'(frame_count), 1);
        frame_end();
        check("t1_nbeats", beats.size() - base, 8);
        check_beat("t1_beat", base + 0, 1'b1, 1'b0, 16'h1234);
        check_beat("t1_beat", base + 1, 1'b0, 1'b0, 16'h5678);
        check_beat("t1_beat", base + 2, 1'b0, 1'b0, 16'h9ABC);
        check_beat("t1_beat", base + 3, 1'b0, 1'b0, 16'hDE00);
        check_beat("t1_beat", base + 4, 1'b0, 1'b0, 16'h2244);
        check_beat("t1_beat", base + 5, 1'b0, 1'b0, 16'h6688);
        check_beat("t1_beat", base + 6, 1'b0, 1'b0, 16'hAACC);
        check_beat("t1_beat", base + 7, 1'b0, 1'b1, 16'hEE10);

        // T2: sink stalled, fifth pixel overflows
        src_ready = 1'b0;
        base = beats.size();
        shutter();
        frame_start();
        send_pixels(4);
        end_line();
        check("t2_no_ovf_yet", 32'(overflow), 0);
        check("t2_head_held", 32'({src_valid, src_sop, src_data}), 32'({2'b11, 16'h1234}));
        send_pixels(1);
        tick();
        check("t2_ovf", 32'(overflow), 1);
        send_pixels(3);
        end_line();
        check("t2_busy_drop", 32'(busy), 1);
        frame_end();
        check("t2_busy_idle", 32'(busy), 0);
        check("t2_head_stable", 32'({src_valid, src_sop, src_eop, src_data}),
              32'({3'b110, 16'h1234}));
        src_ready = 1'b1;
        repeat (6) tick();
        check("t2_nbeats", beats.size() - base, 4);
        check_beat("t2_beat", base + 0, 1'b1, 1'b0, 16'h1234);
        check_beat("t2_beat", base + 1, 1'b0, 1'b0, 16'h5678);
        check_beat("t2_beat", base + 2, 1'b0, 1'b0, 16'h9ABC);
        check_beat("t2_beat", base + 3, 1'b0, 1'b0, 16'hDE00);
        check("t2_count", 32'(frame_count), 1);
        check("t2_empty", 32'(src_valid), 0);
        shutter();
        check("t2_ovf_cleared", 32'(overflow), 0);

        // T3: vsync rises after five pixels (already armed by the shutter above)
        base = beats.size();
        frame_start();
        send_pixels(4);
        end_line();
        send_pixels(1);
        end_line();
        check("t3_no_err_yet", 32'(frame_err), 0);
        frame_end();
        check("t3_err", 32'(frame_err), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_count", 32'(frame_count), 1);
        check("t3_nbeats", beats.size() - base, 5);
        check_beat("t3_beat", base + 0, 1'b1, 1'b0, 16'h1234);
        check_beat("t3_beat", base + 4, 1'b0, 1'b0, 16'h2244);
        neop = 0;
        for (int i = base; i < beats.size(); i++) neop += int'(beats[i][16]);
        check("t3_no_eop", neop, 0);

        // T4: long lines with an odd trailing byte
        shutter();
        check("t4_err_cleared", 32'(frame_err), 0);
        base = beats.size();
        full_frame(6, 1'b1);
        check("t4_nbeats", beats.size() - base, 8);
        check_beat("t4_beat", base + 0, 1'b1, 1'b0, 16'h1234);
        check_beat("t4_beat", base + 3, 1'b0, 1'b0, 16'hDE00);
        check_beat("t4_beat", base + 4, 1'b0, 1'b0, 16'hCCEE);
        check_beat("t4_beat", base + 5, 1'b0, 1'b0, 16'h1032);
        check_beat("t4_beat", base + 6, 1'b0, 1'b0, 16'h5476);
        check_beat("t4_beat", base + 7, 1'b0, 1'b1, 16'h98BA);
        check("t4_count", 32'(frame_count), 2);

        // T5: shutter mid-frame, then three continuous frames
        continuous = 1'b1;
        cam_vsync  = 1'b0;
        repeat (3) tick();
        base = beats.size();
        shutter();
        send_pixels(4);
        end_line();
        check("t5_mid_nbeats", beats.size() - base, 0);
        check("t5_mid_busy", 32'(busy), 1);
        cam_vsync = 1'b1;
        repeat (2) tick();
        full_frame(4, 1'b0);
        full_frame(4, 1'b0);
        continuous = 1'b0;
        full_frame(4, 1'b0);
        check("t5_count", 32'(frame_count), 5);
        check("t5_nbeats", beats.size() - base, 24);
        nsop = 0;
        neop = 0;
        for (int i = base; i < beats.size(); i++) begin
            nsop += int'(beats[i][17]);
            neop += int'(beats[i][16]);
        end
        check("t5_nsop", nsop, 3);
        check("t5_neop", neop, 3);
        check("t5_busy", 32'(busy), 0);

        // T6: reset in the middle of a frame
        src_ready = 1'b0;
        shutter();
        frame_start();
        send_pixels(3);
        repeat (3) tick();
        check("t6_pre_valid", 32'(src_valid), 1);
        reset = 1'b1;
        #2;
        check("t6_valid", 32'(src_valid), 0);
        check("t6_data", 32'(src_data), 0);
        check("t6_sop_eop", 32'({src_sop, src_eop}), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_flags", 32'({overflow, frame_err}), 0);
        check("t6_count", 32'(frame_count), 0);
        reset = 1'b0;
        src_ready = 1'b1;
        base = beats.size();
        send_pixels(1);
        end_line();
        send_pixels(4);
        end_line();
        frame_end();
        full_frame(4, 1'b0);
        check("t6_no_beats", beats.size() - base, 0);
        check("t6_idle", 32'({busy, src_valid}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
